// File: rtl/ofdm_bbp_pkg.sv
// Shared encodings for the OFDM DAC bridge: source modes and read-side FSM states.
package ofdm_bbp_pkg;

  typedef enum logic [1:0] {
    MODE_DMA   = 2'd0,
    MODE_BBP   = 2'd1,
    MODE_ZERO  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } rd_state_e;

  localparam int UNF_CNT_W = 16;

  function automatic logic [UNF_CNT_W-1:0] sat_inc(input logic [UNF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ofdm_sync_fifo.sv
// Single-clock FIFO with synchronous flush; pointers carry a wrap bit so full/empty
// fall out of the pointer difference.
module ofdm_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Push into a full FIFO is only legal alongside a pop; the write slot is the
  // one being read this cycle, so the old entry is still presented on rdata.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = level[DEPTH_LOG2];
  assign empty = (level == '0);

endmodule

// File: rtl/ofdm_dac_sample_bridge.sv
// DAC-side sample mux: DMA passthrough, prefilled BBP FIFO playout, zero or constant,
// with registered outputs and underflow accounting.
module ofdm_dac_sample_bridge
  import ofdm_bbp_pkg::*;
#(
  parameter int NUM_CH     = 1,
  parameter int DW         = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_enable,
  input  logic [1:0]               cfg_mode,
  input  logic [2*DW-1:0]          cfg_const,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*2*DW-1:0]   s_data,
  input  logic                     dac_valid,
  input  logic [NUM_CH*2*DW-1:0]   dma_data,
  input  logic                     dma_dovf,
  input  logic                     dma_dunf,
  output logic [NUM_CH*2*DW-1:0]   dac_data,
  output logic                     dac_dovf,
  output logic                     dac_dunf,
  output logic [DEPTH_LOG2:0]      stat_level,
  output logic [UNF_CNT_W-1:0]     stat_unf_cnt
);
  localparam int SW = NUM_CH * 2 * DW;
  localparam logic [DEPTH_LOG2:0] PREFILL_LVL = PREFILL[DEPTH_LOG2:0];

  rd_state_e       state;
  logic            bbp_sel, pop, unf, push, full, empty;
  logic [SW-1:0]   fifo_rdata, const_rep;
  logic [SW-1:0]   nxt_data;
  logic            nxt_dovf, nxt_dunf;

  assign bbp_sel = cfg_enable && (cfg_mode == MODE_BBP);
  assign pop     = bbp_sel && (state == ST_RUN) && dac_valid && !empty;
  assign unf     = bbp_sel && (state == ST_RUN) && dac_valid &&  empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
  assign s_ready = !rst && bbp_sel && (!full || pop);
  assign push    = s_valid && s_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_const
    assign const_rep[c*2*DW +: 2*DW] = cfg_const;
  end

  ofdm_sync_fifo #(.WIDTH(SW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!bbp_sel),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (stat_level)
  );

  always_comb begin
    nxt_data = dma_data;
    nxt_dovf = dma_dovf;
    nxt_dunf = dma_dunf;
    if (cfg_enable) begin
      case (mode_e'(cfg_mode))
        MODE_BBP: begin
          nxt_data = pop ? fifo_rdata : '0;
          nxt_dovf = 1'b0;
          nxt_dunf = unf;
        end
        MODE_ZERO: begin
          nxt_data = '0;
          nxt_dovf = 1'b0;
          nxt_dunf = 1'b0;
        end
        MODE_CONST: begin
          nxt_data = const_rep;
          nxt_dovf = 1'b0;
          nxt_dunf = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      dac_data     <= '0;
      dac_dovf     <= 1'b0;
      dac_dunf     <= 1'b0;
      stat_unf_cnt <= '0;
    end else begin
      if (!bbp_sel) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:    state <= ST_PREFILL;
          ST_PREFILL: if (stat_level >= PREFILL_LVL) state <= ST_RUN;
          ST_RUN:     if (unf) state <= ST_PREFILL;
          default:    state <= ST_IDLE;
        endcase
      end
      if (dac_valid) dac_data <= nxt_data;
      dac_dovf <= nxt_dovf;
      dac_dunf <= nxt_dunf;
      if (unf) stat_unf_cnt <= sat_inc(stat_unf_cnt);
    end
  end

endmodule

// File: tb/tb_ofdm_dac_sample_bridge.sv
// Directed bench for ofdm_dac_sample_bridge (NUM_CH=2, DEPTH_LOG2=4, PREFILL=8).
module tb_ofdm_dac_sample_bridge;
  import ofdm_bbp_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DW     = 16;
  localparam int DL2    = 4;
  localparam int SW     = NUM_CH * 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [1:0]    cfg_mode;
  logic [31:0]   cfg_const;
  logic          s_valid, s_ready;
  logic [SW-1:0] s_data;
  logic          dac_valid;
  logic [SW-1:0] dma_data;
  logic          dma_dovf, dma_dunf;
  logic [SW-1:0] dac_data;
  logic          dac_dovf, dac_dunf;
  logic [DL2:0]  stat_level;
  logic [15:0]   stat_unf_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ofdm_dac_sample_bridge #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH_LOG2(DL2), .PREFILL(8)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_const(cfg_const),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .dac_valid(dac_valid),
    .dma_data(dma_data), .dma_dovf(dma_dovf), .dma_dunf(dma_dunf),
    .dac_data(dac_data), .dac_dovf(dac_dovf), .dac_dunf(dac_dunf),
    .stat_level(stat_level), .stat_unf_cnt(stat_unf_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_enable = 1'b1; cfg_mode = 2'd0; cfg_const = '0;
    s_valid = 1'b0; s_data = '0; dac_valid = 1'b0;
    dma_data = '0; dma_dovf = 1'b0; dma_dunf = 1'b0;
    tick(); tick();
    chk("rst_dac_data", 64'(dac_data), 64'h0);
    chk("rst_s_ready", 64'(s_ready), 64'h0);
    chk("rst_level", 64'(stat_level), 64'h0);
    chk("rst_unf_cnt", 64'(stat_unf_cnt), 64'h0);
    rst = 1'b0;

    // DMA passthrough
    dma_data = 64'h0000_0000_1234_5678; dma_dunf = 1'b1; dac_valid = 1'b1;
    tick();
    chk("dma_data", 64'(dac_data), 64'h0000_0000_1234_5678);
    chk("dma_dunf", 64'(dac_dunf), 64'h1);
    dac_valid = 1'b0; dma_data = 64'hAAAA_BBBB_CCCC_DDDD; dma_dunf = 1'b0; dma_dovf = 1'b1;
    tick();
    chk("dma_hold", 64'(dac_data), 64'h0000_0000_1234_5678);
    chk("dma_dovf", 64'(dac_dovf), 64'h1);
    chk("dma_dunf_clr", 64'(dac_dunf), 64'h0);
    dma_dovf = 1'b0;

    // BBP prefill
    cfg_mode = 2'd1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      s_valid = 1'b1; s_data = SW'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("pre_level7", 64'(stat_level), 64'd7);
    dac_valid = 1'b1;
    tick();
    dac_valid = 1'b0;
    chk("pre_strobe_data", 64'(dac_data), 64'h0);
    chk("pre_strobe_nopop", 64'(stat_level), 64'd7);
    s_valid = 1'b1; s_data = SW'(8);
    tick();
    s_valid = 1'b0;
    chk("pre_level8", 64'(stat_level), 64'd8);
    tick();
    chk("state_run", 64'(dut.state), 64'(ST_RUN));
    dac_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("play_%0d", i), 64'(dac_data), 64'(i));
    end

    // underflow: dac_valid still high, FIFO now empty
    tick();
    chk("unf_dunf", 64'(dac_dunf), 64'h1);
    chk("unf_data", 64'(dac_data), 64'h0);
    chk("unf_cnt1", 64'(stat_unf_cnt), 64'd1);
    chk("unf_state", 64'(dut.state), 64'(ST_PREFILL));
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("unf_post_dunf_%0d", k), 64'(dac_dunf), 64'h0);
      chk($sformatf("unf_post_cnt_%0d", k), 64'(stat_unf_cnt), 64'd1);
      chk($sformatf("unf_post_data_%0d", k), 64'(dac_data), 64'h0);
    end
    dac_valid = 1'b0;

    // full boundary
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = SW'(32'h100 + i);
      tick();
    end
    s_data = SW'(32'h1FF);
    chk("full_level", 64'(stat_level), 64'd16);
    chk("full_s_ready", 64'(s_ready), 64'h0);
    tick();
    chk("full_nopush", 64'(stat_level), 64'd16);
    s_data = SW'(32'h200); dac_valid = 1'b1;
    #1;
    chk("full_pop_ready", 64'(s_ready), 64'h1);
    tick();
    s_valid = 1'b0;
    chk("full_pp_data", 64'(dac_data), 64'h100);
    chk("full_pp_level", 64'(stat_level), 64'd16);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("full_drain_%0d", i), 64'(dac_data), 64'(32'h100 + i));
    end
    tick();
    chk("full_drain_last", 64'(dac_data), 64'h200);
    dac_valid = 1'b0;
    chk("full_drained", 64'(stat_level), 64'd0);

    // reset mid-operation
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = SW'(32'h300 + i);
      tick();
    end
    s_valid = 1'b0;
    chk("mid_level5", 64'(stat_level), 64'd5);
    chk("mid_state_run", 64'(dut.state), 64'(ST_RUN));
    rst = 1'b1;
    #2;
    chk("mid_rst_level", 64'(stat_level), 64'd0);
    chk("mid_rst_state", 64'(dut.state), 64'(ST_IDLE));
    chk("mid_rst_data", 64'(dac_data), 64'h0);
    chk("mid_rst_cnt", 64'(stat_unf_cnt), 64'h0);
    chk("mid_rst_ready", 64'(s_ready), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = SW'(32'h400 + i);
      tick();
    end
    s_valid = 1'b0; dac_valid = 1'b1;
    tick();
    dac_valid = 1'b0;
    chk("post_rst_data", 64'(dac_data), 64'h0);
    chk("post_rst_level", 64'(stat_level), 64'd3);

    // constant and zero modes
    cfg_mode = 2'd3; cfg_const = 32'h7FFF_8001; dac_valid = 1'b1;
    tick();
    chk("const_data", 64'(dac_data), 64'h7FFF_8001_7FFF_8001);
    chk("const_flush", 64'(stat_level), 64'd0);
    chk("const_dunf", 64'(dac_dunf), 64'h0);
    cfg_mode = 2'd2;
    tick();
    chk("zero_data", 64'(dac_data), 64'h0);

    // disabled -> DMA source regardless of mode
    cfg_enable = 1'b0; cfg_mode = 2'd1; dma_data = 64'hDEAD_BEEF_0BAD_F00D; dma_dovf = 1'b1;
    tick();
    dac_valid = 1'b0;
    chk("dis_data", 64'(dac_data), 64'hDEAD_BEEF_0BAD_F00D);
    chk("dis_dovf", 64'(dac_dovf), 64'h1);
    chk("dis_ready", 64'(s_ready), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
